// File: rtl/fir_tcdm_responder.sv
// Banked, word-interleaved TCDM slave model: per-bank round-robin grants, 1-cycle responses, out-of-window flag.
// Define FIR_TCDM_STALL_EN to add per-port LFSR-driven grant stalls.
module fir_tcdm_responder #(
    parameter int unsigned MP           = 4,
    parameter int unsigned N_BANKS      = 4,
    parameter int unsigned BANK_DEPTH   = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int unsigned STALL_THRESH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [MP-1:0]      tcdm_req,
    output logic [MP-1:0]      tcdm_gnt,
    input  logic [MP*32-1:0]   tcdm_add,
    input  logic [MP-1:0]      tcdm_wen,
    input  logic [MP*4-1:0]    tcdm_be,
    input  logic [MP*32-1:0]   tcdm_data,
    output logic [MP*32-1:0]   tcdm_r_data,
    output logic [MP-1:0]      tcdm_r_valid,
    output logic               err_o,
    input  logic               err_clr_i
);
    localparam int unsigned BANK_W    = $clog2(N_BANKS);
    localparam int unsigned ROW_W     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int unsigned PTR_W     = (MP > 1) ? $clog2(MP) : 1;
    localparam logic [31:0] WIN_BYTES = 32'(N_BANKS * BANK_DEPTH * 4);
    localparam logic [31:0] OOW_RDATA = 32'hBADC_AB1E;

    logic [MP-1:0][31:0]          off_c;
    logic [MP-1:0]                in_win_c;
    logic [MP-1:0]                stall_c;
    logic [MP-1:0]                cand_c;
    logic [MP-1:0][BANK_W-1:0]    bank_c;
    logic [MP-1:0][ROW_W-1:0]     row_c;
    logic [N_BANKS-1:0][PTR_W-1:0] ptr_q, ptr_d;
    logic [MP-1:0]                r_valid_q, r_valid_d;
    logic [MP-1:0][31:0]          r_data_q, r_data_d;
    logic                         err_q, err_d;
    logic [31:0]                  mem [N_BANKS][BANK_DEPTH];

`ifdef FIR_TCDM_STALL_EN
    logic [MP-1:0][15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 per port; low nibble below threshold stalls the port.
    always_comb begin
        lfsr_d  = lfsr_q;
        stall_c = '0;
        for (int p = 0; p < MP; p++) begin
            lfsr_d[p]  = {lfsr_q[p][14:0],
                          lfsr_q[p][15] ^ lfsr_q[p][13] ^ lfsr_q[p][12] ^ lfsr_q[p][10]};
            stall_c[p] = 32'(lfsr_q[p][3:0]) < STALL_THRESH;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < MP; p++) lfsr_q[p] <= 16'hACE1 + 16'(p);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall_c = '0;
`endif

    // Address decode; addresses below the base wrap to a huge offset and fall out of window.
    always_comb begin
        off_c    = '0;
        in_win_c = '0;
        bank_c   = '0;
        row_c    = '0;
        cand_c   = '0;
        for (int p = 0; p < MP; p++) begin
            off_c[p]    = tcdm_add[p*32 +: 32] - BASE_ADDR;
            in_win_c[p] = off_c[p] < WIN_BYTES;
            bank_c[p]   = off_c[p][2 +: BANK_W];
            row_c[p]    = ROW_W'(off_c[p] >> (2 + BANK_W));
            cand_c[p]   = tcdm_req[p] & ~stall_c[p];
        end
    end

    // Out-of-window requests bypass arbitration; each bank grants one in-window candidate round-robin.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        tcdm_gnt = '0;
        ptr_d    = ptr_q;
        found    = 1'b0;
        idx      = '0;
        for (int p = 0; p < MP; p++) begin
            if (cand_c[p] && !in_win_c[p]) tcdm_gnt[p] = 1'b1;
        end
        for (int b = 0; b < N_BANKS; b++) begin
            found = 1'b0;
            for (int k = 0; k < MP; k++) begin
                idx = PTR_W'((32'(ptr_q[b]) + 32'(k)) % MP);
                if (!found && cand_c[idx] && in_win_c[idx] && bank_c[idx] == BANK_W'(b)) begin
                    found         = 1'b1;
                    tcdm_gnt[idx] = 1'b1;
                    ptr_d[b]      = PTR_W'((32'(idx) + 32'd1) % MP);
                end
            end
        end
    end

    always_comb begin
        r_valid_d = tcdm_gnt;
        r_data_d  = r_data_q;
        err_d     = err_q & ~err_clr_i;
        for (int p = 0; p < MP; p++) begin
            if (tcdm_gnt[p]) begin
                if (!in_win_c[p]) begin
                    err_d       = 1'b1;
                    r_data_d[p] = tcdm_wen[p] ? OOW_RDATA : 32'h0;
                end else begin
                    r_data_d[p] = tcdm_wen[p] ? mem[bank_c[p]][row_c[p]] : 32'h0;
                end
            end
        end
    end

    // Storage is deliberately never reset so content survives rst_i.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++) begin
            if (tcdm_gnt[p] && in_win_c[p] && !tcdm_wen[p]) begin
                for (int k = 0; k < 4; k++) begin
                    if (tcdm_be[p*4 + k])
                        mem[bank_c[p]][row_c[p]][k*8 +: 8] <= tcdm_data[p*32 + k*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            r_valid_q <= '0;
            r_data_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            err_q     <= err_d;
        end
    end

    assign tcdm_r_valid = r_valid_q;
    assign tcdm_r_data  = r_data_q;
    assign err_o        = err_q;

endmodule
